// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// scan_pkg : shared widths, FSM encoding and width helper for scan_scheduler
// Revision : 1.0
// ============================================================================
package scan_pkg;

    localparam int SEL_W           = 9;
    localparam int IO_W            = 8;
    localparam int DEF_NUM_DESIGNS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT     = 3'd1,
        ST_WAIT_LOAD = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_CAPTURE   = 3'd4
    } state_t;

    // Never returns less than 1 so single-entry ranges still get a real bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick, searching upward from ptr+1
// Revision   : 1.0
// ============================================================================
module rr_arbiter
    import scan_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [clog2(N)-1:0]   ptr,
    output logic [N-1:0]          grant,
    output logic [clog2(N)-1:0]   grant_idx
);

    localparam int IDX_W = clog2(N);

    logic [IDX_W-1:0] slot;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        slot      = '0;
        for (int off = N; off >= 1; off--) begin
            slot = IDX_W'((int'(ptr) + off) % N);
            if (req[slot]) begin
                grant     = N'(1) << slot;
                grant_idx = slot;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/scan_scheduler.sv
`default_nettype none
// ============================================================================
// scan_scheduler : round-robin sharing of one scan_controller between requesters
// Revision       : 1.0
// ============================================================================
module scan_scheduler
    import scan_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int NUM_DESIGNS    = DEF_NUM_DESIGNS,
    parameter int NUM_IOS        = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [SEL_W*NUM_REQ-1:0]  req_select,
    input  logic [IO_W*NUM_REQ-1:0]   req_inputs,
    output logic [NUM_REQ-1:0]        done,
    output logic [IO_W-1:0]           resp_data,
    output logic                      resp_err,
    output logic                      busy,
    output logic                      timeout_flag,
    output logic [SEL_W-1:0]          ctrl_select,
    output logic [IO_W-1:0]           ctrl_inputs,
    input  logic                      ctrl_ready,
    input  logic [IO_W-1:0]           ctrl_outputs
);

    localparam int IDX_W = clog2(NUM_REQ);
    localparam int CNT_W = clog2(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_REQ - 1);
    localparam logic [SEL_W-1:0] MAX_SEL  = SEL_W'(NUM_DESIGNS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    generate
        if (NUM_IOS != IO_W) begin : g_bad_ios
            $error("scan_scheduler supports exactly %0d I/O bits per design", IO_W);
        end
    endgenerate

    state_t               state;
    logic [IDX_W-1:0]     ptr;
    logic [NUM_REQ-1:0]   win_oh;
    logic [SEL_W-1:0]     sel_q;
    logic [IO_W-1:0]      in_q;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     grant_idx;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            ptr          <= PTR_INIT;
            win_oh       <= '0;
            sel_q        <= '0;
            in_q         <= '0;
            cnt          <= '0;
            done         <= '0;
            resp_data    <= '0;
            resp_err     <= 1'b0;
            timeout_flag <= 1'b0;
            ctrl_select  <= '0;
            ctrl_inputs  <= '0;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        win_oh <= grant;
                        ptr    <= grant_idx;
                        sel_q  <= req_select[grant_idx*SEL_W +: SEL_W];
                        in_q   <= req_inputs[grant_idx*IO_W +: IO_W];
                        state  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (sel_q >= MAX_SEL) begin
                        done      <= win_oh;
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        ctrl_select <= sel_q;
                        ctrl_inputs <= in_q;
                        cnt         <= '0;
                        state       <= ST_WAIT_LOAD;
                    end
                end
                // First ready starts the pass, second ready ends it.
                ST_WAIT_LOAD, ST_WAIT_DONE: begin
                    if (ctrl_ready) begin
                        cnt   <= '0;
                        state <= (state == ST_WAIT_LOAD) ? ST_WAIT_DONE : ST_CAPTURE;
                    end else if (cnt == CNT_LAST) begin
                        done         <= win_oh;
                        resp_data    <= '0;
                        resp_err     <= 1'b1;
                        timeout_flag <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    resp_data <= ctrl_outputs;
                    resp_err  <= 1'b0;
                    done      <= win_oh;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/scan_scheduler.md
Name: scan_scheduler

Overview:
- Shares one scan_controller between NUM_REQ independent requesters, using round-robin arbitration.
- Each transaction is: requester supplies a design select and an 8-bit input vector; the block drives the controller's active_select/inputs for one complete scan pass; it returns the captured design outputs.
- Sits directly above scan_controller.
- Owns ctrl_select/ctrl_inputs stability and watches the controller's ready pulse to frame each pass.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_DESIGNS, 8, designs on the scan chain; a select at or above this is out of range.
- NUM_IOS, 8, I/O bits per design; fixed at 8 here.
- TIMEOUT_CYCLES, 1024, max cycles spent in either wait state. Must exceed 4*NUM_DESIGNS*NUM_IOS+8.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_select  in  9*NUM_REQ  flat bus; slice i is requester i's design select.
- req_inputs  in  8*NUM_REQ  flat bus; slice i is requester i's input vector.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- resp_data  out  8  captured outputs; valid while any done bit is high, held until the next done.
- resp_err  out  1  qualifies done: out-of-range select or timeout.
- busy  out  1  high in every state except IDLE.
- timeout_flag  out  1  sticky; set on any timeout, cleared only by reset.
- ctrl_select  out  9  to scan_controller active_select.
- ctrl_inputs  out  8  to scan_controller inputs.
- ctrl_ready  in  1  from scan_controller ready; high for one cycle at the start of each pass.
- ctrl_outputs  in  8  from scan_controller outputs.

Behaviour:
- Reset values:
  - state IDLE.
  - done, resp_data, resp_err, busy, timeout_flag, ctrl_select, ctrl_inputs all 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- States: IDLE, GRANT, WAIT_LOAD, WAIT_DONE, CAPTURE.
- IDLE:
  - If any req bit is set, the arbiter picks the first set bit searching upward from pointer+1 (mod NUM_REQ).
  - Latch the winner's index, select and inputs; update pointer to the winner; go to GRANT.
  - No request: stay in IDLE and hold ctrl_select/ctrl_inputs at their last values.
- GRANT:
  - Latched select >= NUM_DESIGNS: pulse done[winner] with resp_err=1 and resp_data=0, then go to IDLE. No scan pass occurs and ctrl_* are not changed.
  - Otherwise: drive ctrl_select/ctrl_inputs from the latched values, clear the timeout counter, go to WAIT_LOAD.
- WAIT_LOAD:
  - ctrl_ready=1: the controller samples inputs at this edge. Clear the counter and go to WAIT_DONE.
  - ctrl_ready is not accepted in the same cycle ctrl_* were first driven. GRANT is a full cycle, so the earliest accepted pulse is the first WAIT_LOAD cycle.
- WAIT_DONE:
  - ctrl_ready=1 marks the pass complete; go to CAPTURE.
  - The controller updates its outputs on this edge.
- CAPTURE:
  - Register ctrl_outputs into resp_data; pulse done[winner] with resp_err=0; go to IDLE.
  - ctrl_select/ctrl_inputs stay held. The controller's next pass re-uses them harmlessly.
- Timeout:
  - The counter increments every cycle in WAIT_LOAD and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES-1 without ctrl_ready: pulse done[winner] with resp_err=1 and resp_data=0, set timeout_flag, go to IDLE.
- ctrl_select/ctrl_inputs change only on the GRANT->WAIT_LOAD edge. They are stable from grant through CAPTURE.
- Requesters:
  - Hold req until their done pulse.
  - A req still high on the cycle after done is a new request and competes normally (round-robin: it loses to any other pending requester).
  - Dropping req after grant does not abort the transaction; done still pulses.
- Latency: req→GRANT is 1 cycle. Best case request-to-done is 3 cycles plus two ctrl_ready intervals. Back-to-back transactions have one IDLE cycle between done and the next grant.
- Asynchronous reset mid-transaction: immediate return to reset values. No done pulse is issued for the aborted transaction.

Decomposition:
- Shared package scan_pkg holds:
  - state encoding constants.
  - SEL_W=9, IO_W=8.
  - the default NUM_DESIGNS.
  - the timeout-width function clog2.
- One sub-module, rr_arbiter:
  - parameter N.
  - inputs req[N], ptr.
  - outputs grant one-hot and grant index, combinational.
- The scheduler FSM, latches and counter stay in scan_scheduler.

Test Plan:
- Bench setup: NUM_REQ=4, NUM_DESIGNS=8, scan_scheduler driving a real scan_controller plus a behavioural 8-design chain in which design k outputs inputs XOR k.
1. Single request: req[2]=1, select=5, inputs=0xA0 → done[2] pulses once with resp_data=0xA5 and resp_err=0. ctrl_select stays 5 from grant to done.
2. Fairness: req=4'b1111 held continuously → grant order 0,1,2,3,0; each done is one-hot; no requester served twice before the others.
3. Out-of-range: req[1]=1, select=9 → done[1] two cycles later with resp_err=1 and resp_data=0x00. ctrl_select unchanged and no ctrl_ready wait.
4. Timeout: TIMEOUT_CYCLES=64, ctrl_ready tied 0 → done pulses 64 cycles after entering WAIT_LOAD, resp_err=1, timeout_flag=1 until reset.
5. Reset mid-pass: assert reset in WAIT_DONE → all outputs 0 immediately (asynchronous), no done pulse. A fresh req[0] afterwards completes correctly.
6. Back-to-back: req[3] select=0 inputs=0x0F, then select=7 inputs=0xF0 → responses 0x0F and 0xF7, each with exactly one IDLE cycle between done and the next grant.
